reg_cmd_sequencer: RTL and testbench

Command sequencer between the Master-FPGA link word stream and the register block. It parses 32-bit command headers and issues the register-number latch, write and read strobes in the order the register block requires. It returns read-back data and one status word per command on an outgoing word stream. It supports bursts of up to 32 consecutive registers.

---
 rtl/reg_cmd_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_reg_cmd_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_cmd_sequencer.sv
// Command sequencer between the link word stream and the register block: parses headers,
// issues select/write/read strobes per register and returns read data plus a status word.
module reg_cmd_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] rx_word,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [31:0] tx_word,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] reg_data,
  output logic        reg_num_le,
  output logic        reg_wr_en,
  output logic        reg_rd_en,
  input  logic [31:0] reg_rd_data,
  input  logic        illegal_reg_num,
  output logic        busy
);

  typedef enum logic [3:0] {
    StIdle,
    StDecode,
    StSel,
    StChk,
    StWdata,
    StWr,
    StRd,
    StRwait,
    StRpush,
    StDrain,
    StStatus
  } state_e;

  localparam logic [3:0] OpWrite = 4'h1;
  localparam logic [3:0] OpRead  = 4'h2;

  state_e      state_q, state_d;
  logic [3:0]  opcode_q, opcode_d;
  logic [5:0]  count_q, count_d;
  logic [21:0] cur_reg_q, cur_reg_d;
  logic [5:0]  done_q, done_d;
  logic [5:0]  drain_q, drain_d;
  logic        bad_op_q, bad_op_d;
  logic        zero_cnt_q, zero_cnt_d;
  logic        ill_reg_q, ill_reg_d;
  logic        rx_ready_q, rx_ready_d;
  logic [31:0] tx_word_q;
  logic        tx_valid_q;
  logic [31:0] reg_data_q;
  logic        rx_fire, tx_fire, is_write, ok_d;
  logic [31:0] status_d;

  assign rx_fire  = rx_valid && rx_ready_q;
  assign tx_fire  = tx_valid_q && tx_ready;
  assign is_write = (opcode_q == OpWrite);

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    count_d    = count_q;
    cur_reg_d  = cur_reg_q;
    done_d     = done_q;
    drain_d    = drain_q;
    bad_op_d   = bad_op_q;
    zero_cnt_d = zero_cnt_q;
    ill_reg_d  = ill_reg_q;
    unique case (state_q)
      StIdle: begin
        if (rx_fire) begin
          opcode_d   = rx_word[31:28];
          count_d    = rx_word[27:22];
          cur_reg_d  = rx_word[21:0];
          done_d     = '0;
          bad_op_d   = 1'b0;
          zero_cnt_d = 1'b0;
          ill_reg_d  = 1'b0;
          state_d    = StDecode;
        end
      end
      StDecode: begin
        if (opcode_q != OpWrite && opcode_q != OpRead) begin
          bad_op_d = 1'b1;
          state_d  = StStatus;
        end else if (count_q == 6'd0) begin
          zero_cnt_d = 1'b1;
          state_d    = StStatus;
        end else begin
          state_d = StSel;
        end
      end
      StSel: state_d = StChk;
      StChk: begin
        if (illegal_reg_num) begin
          ill_reg_d = 1'b1;
          if (is_write) begin
            // Words for the current and all later registers are still pending on rx.
            drain_d = count_q - done_q;
            state_d = StDrain;
          end else begin
            state_d = StStatus;
          end
        end else begin
          state_d = is_write ? StWdata : StRd;
        end
      end
      StWdata: begin
        if (rx_fire) state_d = StWr;
      end
      StWr: begin
        done_d    = done_q + 6'd1;
        cur_reg_d = cur_reg_q + 22'd1;
        state_d   = (done_d == count_q) ? StStatus : StSel;
      end
      StRd:    state_d = StRwait;
      StRwait: state_d = StRpush;
      StRpush: begin
        if (tx_fire) begin
          done_d    = done_q + 6'd1;
          cur_reg_d = cur_reg_q + 22'd1;
          state_d   = (done_d == count_q) ? StStatus : StSel;
        end
      end
      StDrain: begin
        if (rx_fire) begin
          drain_d = drain_q - 6'd1;
          if (drain_q == 6'd1) state_d = StStatus;
        end
      end
      StStatus: begin
        if (tx_fire) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign ok_d       = ~(bad_op_d | zero_cnt_d | ill_reg_d);
  assign status_d   = {opcode_d, count_d, done_d, 12'b0, bad_op_d, zero_cnt_d, ill_reg_d, ok_d};
  assign rx_ready_d = (state_d == StIdle) || (state_d == StWdata) || (state_d == StDrain);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      opcode_q   <= '0;
      count_q    <= '0;
      cur_reg_q  <= '0;
      done_q     <= '0;
      drain_q    <= '0;
      bad_op_q   <= 1'b0;
      zero_cnt_q <= 1'b0;
      ill_reg_q  <= 1'b0;
      rx_ready_q <= 1'b0;
      tx_word_q  <= '0;
      tx_valid_q <= 1'b0;
      reg_data_q <= '0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      count_q    <= count_d;
      cur_reg_q  <= cur_reg_d;
      done_q     <= done_d;
      drain_q    <= drain_d;
      bad_op_q   <= bad_op_d;
      zero_cnt_q <= zero_cnt_d;
      ill_reg_q  <= ill_reg_d;
      rx_ready_q <= rx_ready_d;

      if (state_d == StSel) begin
        reg_data_q <= {10'b0, cur_reg_d};
      end else if (state_q == StWdata && rx_fire) begin
        reg_data_q <= rx_word;
      end

      // Later assignments override the handshake clear when a new word is loaded.
      if (tx_fire) tx_valid_q <= 1'b0;
      if (state_q == StRwait) begin
        tx_word_q  <= reg_rd_data;
        tx_valid_q <= 1'b1;
      end
      if (state_d == StStatus && state_q != StStatus) begin
        tx_word_q  <= status_d;
        tx_valid_q <= 1'b1;
      end
    end
  end

  assign rx_ready   = rx_ready_q;
  assign tx_word    = tx_word_q;
  assign tx_valid   = tx_valid_q;
  assign reg_data   = reg_data_q;
  assign reg_num_le = (state_q == StSel);
  assign reg_wr_en  = (state_q == StWr);
  assign reg_rd_en  = (state_q == StRd);
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_reg_cmd_sequencer.sv
// Directed bench for reg_cmd_sequencer with a behavioural register block and stream monitors.
module tb_reg_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rx_word;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] tx_word;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] reg_data;
  logic        reg_num_le;
  logic        reg_wr_en;
  logic        reg_rd_en;
  logic [31:0] reg_rd_data;
  logic        illegal_reg_num;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

  always #4 clk = ~clk;

  reg_cmd_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .rx_word        (rx_word),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .tx_word        (tx_word),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .reg_data       (reg_data),
    .reg_num_le     (reg_num_le),
    .reg_wr_en      (reg_wr_en),
    .reg_rd_en      (reg_rd_en),
    .reg_rd_data    (reg_rd_data),
    .illegal_reg_num(illegal_reg_num),
    .busy           (busy)
  );

  // Register block model: number latched on reg_num_le, read-back registered on reg_rd_en.
  logic [31:0] regs [32];
  logic [21:0] sel_num;
  logic [31:0] rdback;

  assign illegal_reg_num = (sel_num > 22'd31);
  assign reg_rd_data     = rdback;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'hA000_0000 + 32'(i);
      sel_num <= '0;
      rdback  <= '0;
    end else begin
      if (reg_num_le) sel_num <= reg_data[21:0];
      if (reg_wr_en && !illegal_reg_num) regs[sel_num[4:0]] <= reg_data;
      if (reg_rd_en) rdback <= illegal_reg_num ? 32'hDEAD_BEEF : regs[sel_num[4:0]];
    end
  end

  logic [31:0] txq[$];
  logic [31:0] le_dat[$];
  logic [31:0] wr_num[$];
  logic [31:0] wr_dat[$];
  int          rd_cnt     = 0;
  int          strobe_err = 0;
  int          stab_err   = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_word  = '0;

  always @(negedge clk) begin
    if (!reset) begin
      if (tx_valid && tx_ready) txq.push_back(tx_word);
      if (reg_num_le) le_dat.push_back(reg_data);
      if (reg_wr_en) begin
        wr_num.push_back({10'b0, sel_num});
        wr_dat.push_back(reg_data);
      end
      if (reg_rd_en) rd_cnt++;
    end
    if (32'(reg_num_le) + 32'(reg_wr_en) + 32'(reg_rd_en) > 1) strobe_err++;
    if (prev_stall && !(tx_valid && tx_word == prev_word)) stab_err++;
    prev_stall = tx_valid && !tx_ready && !reset;
    prev_word  = tx_word;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that consumed w.
  task automatic send_word(input logic [31:0] w);
    int n = 0;
    rx_word  = w;
    rx_valid = 1'b1;
    while (!rx_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!rx_ready) chk("rx_accept", {31'b0, rx_ready}, 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input string tag, input int n, input bit toggle);
    int k = 0;
    while (txq.size() < n && k < 500) begin
      @(posedge clk);
      #1;
      if (toggle) tx_ready = ~tx_ready;
      k++;
    end
    chk(tag, 32'(txq.size()), 32'(n));
  endtask

  int tb, lb, wb, rb, k;

  initial begin
    reset    = 1'b1;
    rx_word  = '0;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_ready", {31'b0, rx_ready}, 32'd0);
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("rst_tx_word", tx_word, 32'd0);
    chk("rst_reg_data", reg_data, 32'd0);
    chk("rst_strobes", {29'b0, reg_num_le, reg_wr_en, reg_rd_en}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rx_ready_rise", {31'b0, rx_ready}, 32'd1);

    // Single write of 1000 to reg 2.
    tb = txq.size(); lb = le_dat.size(); wb = wr_dat.size(); rb = rd_cnt;
    tx_ready = 1'b1;
    send_word(32'h1040_0002);
    send_word(32'd1000);
    wait_tx("wr1_words", tb + 1, 1'b0);
    chk("wr1_status", txq[tb], 32'h1041_0001);
    chk("wr1_sel_data", le_dat[lb], 32'd2);
    chk("wr1_wr_count", 32'(wr_dat.size() - wb), 32'd1);
    chk("wr1_wr_num", wr_num[wb], 32'd2);
    chk("wr1_wr_data", wr_dat[wb], 32'd1000);
    chk("wr1_no_reads", 32'(rd_cnt - rb), 32'd0);

    // Read burst of 4 from reg 2 with tx_ready toggling.
    tb = txq.size(); rb = rd_cnt;
    tx_ready = 1'b0;
    send_word(32'h2100_0002);
    wait_tx("rd4_words", tb + 5, 1'b1);
    tx_ready = 1'b1;
    chk("rd4_data0", txq[tb],     32'd1000);
    chk("rd4_data1", txq[tb + 1], 32'hA000_0003);
    chk("rd4_data2", txq[tb + 2], 32'hA000_0004);
    chk("rd4_data3", txq[tb + 3], 32'hA000_0005);
    chk("rd4_status", txq[tb + 4], 32'h2104_0001);
    chk("rd4_rd_count", 32'(rd_cnt - rb), 32'd4);
    chk("rd4_tx_stable", 32'(stab_err), 32'd0);

    // Write of 3 starting at reg 30: third register is illegal and its word is drained.
    tb = txq.size(); lb = le_dat.size(); wb = wr_dat.size();
    send_word(32'h10C0_001E);
    send_word(32'h1111_1111);
    send_word(32'h2222_2222);
    send_word(32'h3333_3333);
    wait_tx("wr3_words", tb + 1, 1'b0);
    chk("wr3_status", txq[tb], 32'h10C2_0002);
    chk("wr3_wr_count", 32'(wr_dat.size() - wb), 32'd2);
    chk("wr3_num0", wr_num[wb], 32'd30);
    chk("wr3_num1", wr_num[wb + 1], 32'd31);
    chk("wr3_dat0", wr_dat[wb], 32'h1111_1111);
    chk("wr3_dat1", wr_dat[wb + 1], 32'h2222_2222);
    chk("wr3_sel_count", 32'(le_dat.size() - lb), 32'd3);
    chk("wr3_sel_last", le_dat[lb + 2], 32'd32);
    chk("wr3_idle_after", {31'b0, busy}, 32'd0);

    // Bad opcode and zero count: status only, no strobes.
    tb = txq.size(); lb = le_dat.size(); wb = wr_dat.size(); rb = rd_cnt;
    send_word(32'h7000_0000);
    wait_tx("badop_words", tb + 1, 1'b0);
    chk("badop_status", txq[tb], 32'h7000_0008);
    send_word(32'h1000_0005);
    wait_tx("zcnt_words", tb + 2, 1'b0);
    chk("zcnt_status", txq[tb + 1], 32'h1000_0004);
    chk("err_no_strobes", 32'((le_dat.size() - lb) + (wr_dat.size() - wb) + (rd_cnt - rb)),
        32'd0);

    // Read burst of 8 from reg 0, reset during the third RPUSH.
    tb = txq.size();
    send_word(32'h2200_0000);
    k = 0;
    while (txq.size() < tb + 2 && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    tx_ready = 1'b0;
    chk("rst8_first_words", 32'(txq.size() - tb), 32'd2);
    chk("rst8_data0", txq[tb], 32'hA000_0000);
    chk("rst8_data1", txq[tb + 1], 32'hA000_0001);
    k = 0;
    while (!tx_valid && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("rst8_third_push", {31'b0, tx_valid}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst8_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("rst8_busy", {31'b0, busy}, 32'd0);
    chk("rst8_strobes", {29'b0, reg_num_le, reg_wr_en, reg_rd_en}, 32'd0);
    tx_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("rst8_no_status", 32'(txq.size() - tb), 32'd2);

    tb = txq.size();
    send_word(32'h2040_0007);
    wait_tx("rd1_words", tb + 2, 1'b0);
    chk("rd1_data", txq[tb], 32'hA000_0007);
    chk("rd1_status", txq[tb + 1], 32'h2041_0001);

    chk("strobe_onehot", 32'(strobe_err), 32'd0);
    chk("tx_stable_all", 32'(stab_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
